// File: rtl/dma_seq_pkg.sv
// Shared state encoding and transfer-mode constants for the DMA chunk sequencer.
// Imported by the top level and by the bench.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] TF_MODE_IDLE      = 2'd0;
  localparam logic [1:0] TF_MODE_READ_RAM  = 2'd1;
  localparam logic [1:0] TF_MODE_WRITE_RAM = 2'd2;

endpackage

// File: rtl/dma_watchdog.sv
// WAIT-state watchdog: counts enabled cycles from 1, pulses timeout in the cycle the
// count equals a nonzero limit; clear has priority, limit 0 never fires.
module dma_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 timeout
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic [TIMEOUT_W-1:0] cnt_cur;

  // cnt_q holds completed cycles, so the cycle being evaluated is cnt_q + 1.
  assign cnt_cur = cnt_q + TIMEOUT_W'(1);

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d   = cnt_cur;
      timeout = (limit != '0) && (cnt_cur == limit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dma_chunk_sequencer.sv
// Splits a byte-length job into DMA commands of at most CHUNK_BYTES; first INIT
// INIT_DELAY+1 cycles after the start edge; one command outstanding, no cancel.
module dma_chunk_sequencer
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 32,
  parameter int CHUNK_BYTES = 4096,
  parameter int NUM_SLOTS   = 4,
  parameter int INIT_DELAY  = 2,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                          I_ACLK,
  input  logic                          I_ARESET,
  input  logic                          I_START,
  input  logic                          I_ABORT,
  input  logic [$clog2(NUM_SLOTS)-1:0]  I_SLOT,
  input  logic [NUM_SLOTS*ADDR_W-1:0]   I_SLOT_ADDR,
  input  logic [NUM_SLOTS*2-1:0]        I_SLOT_MODE,
  input  logic [LEN_W-1:0]              I_BYTE_TO_TRANSFER,
  input  logic [TIMEOUT_W-1:0]          I_TIMEOUT_CYCLES,
  output logic                          O_BUSY,
  output logic                          O_DONE,
  output logic                          O_ERROR,
  output logic [LEN_W-1:0]              O_CHUNKS_DONE,
  output logic [ADDR_W-1:0]             O_DMA_REG_ADDRESS,
  output logic [LEN_W-1:0]              O_DMA_REG_DATA,
  output logic                          O_DMA_INIT_AXI_TXN,
  input  logic                          I_DMA_AXI_TXN_DONE,
  output logic [1:0]                    O_DMA_TRANSFER_MODE
);

  localparam int                ISS_W      = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam logic [ISS_W-1:0]  ISS_LAST   = ISS_W'(INIT_DELAY - 1);
  localparam logic [LEN_W-1:0]  CHUNK_LEN  = LEN_W'(CHUNK_BYTES);
  localparam logic [ADDR_W-1:0] CHUNK_STEP = ADDR_W'(CHUNK_BYTES);

  function automatic logic [LEN_W-1:0] chunk_len(input logic [LEN_W-1:0] rem);
    return (rem < CHUNK_LEN) ? rem : CHUNK_LEN;
  endfunction

  state_e                 state_q,    state_d;
  logic                   start_q,    start_d;
  logic                   abort_q,    abort_d;
  logic                   error_q,    error_d;
  logic [1:0]             mode_q,     mode_d;
  logic [LEN_W-1:0]       rem_q,      rem_d;
  logic [TIMEOUT_W-1:0]   tmo_q,      tmo_d;
  logic [LEN_W-1:0]       chunks_q,   chunks_d;
  logic [ISS_W-1:0]       issue_q,    issue_d;
  logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
  logic [LEN_W-1:0]       reg_data_q, reg_data_d;

  logic                   start_edge;
  logic                   abort_pend;
  logic                   init_pulse;
  logic                   wd_timeout;
  logic [LEN_W-1:0]       rem_after;
  logic [ADDR_W-1:0]      slot_addr;
  logic [1:0]             slot_mode;

  assign start_edge = I_START & ~start_q;
  assign abort_pend = abort_q | I_ABORT;
  assign rem_after  = rem_q - reg_data_q;
  assign slot_addr  = I_SLOT_ADDR[I_SLOT*ADDR_W +: ADDR_W];
  assign slot_mode  = I_SLOT_MODE[I_SLOT*2 +: 2];

  dma_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (I_ACLK),
    .rst     (I_ARESET),
    .en      (state_q == ST_WAIT),
    .clr     (state_q != ST_WAIT),
    .limit   (tmo_q),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = I_START;
    abort_d    = abort_q;
    error_d    = error_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    tmo_d      = tmo_q;
    chunks_d   = chunks_q;
    issue_d    = issue_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    init_pulse = 1'b0;

    if (state_q != ST_IDLE && I_ABORT) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_SETUP;
          mode_d     = slot_mode;
          rem_d      = I_BYTE_TO_TRANSFER;
          tmo_d      = I_TIMEOUT_CYCLES;
          error_d    = 1'b0;
          abort_d    = 1'b0;
          chunks_d   = '0;
          reg_addr_d = slot_addr;
          reg_data_d = chunk_len(I_BYTE_TO_TRANSFER);
        end
      end

      ST_SETUP: begin
        issue_d = '0;
        if (rem_q == '0 || abort_pend) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      // An abort seen in the INIT cycle suppresses the pulse, so no command escapes.
      ST_ISSUE: begin
        if (abort_pend) begin
          state_d = ST_DONE;
        end else if (issue_q == ISS_LAST) begin
          init_pulse = 1'b1;
          state_d    = ST_WAIT;
        end else begin
          issue_d = issue_q + ISS_W'(1);
        end
      end

      ST_WAIT: begin
        if (I_DMA_AXI_TXN_DONE) begin
          state_d = ST_NEXT;
        end else if (wd_timeout) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_NEXT: begin
        chunks_d = chunks_q + LEN_W'(1);
        rem_d    = rem_after;
        if (rem_after == '0 || abort_pend) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_SETUP;
          reg_addr_d = reg_addr_q + CHUNK_STEP;
          reg_data_d = chunk_len(rem_after);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every path into DONE drops the command registers and reports a pending abort.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      reg_addr_d = '0;
      reg_data_d = '0;
      if (abort_pend) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_ACLK or posedge I_ARESET) begin
    if (I_ARESET) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      error_q    <= 1'b0;
      mode_q     <= TF_MODE_IDLE;
      rem_q      <= '0;
      tmo_q      <= '0;
      chunks_q   <= '0;
      issue_q    <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      error_q    <= error_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      chunks_q   <= chunks_d;
      issue_q    <= issue_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign O_BUSY              = (state_q != ST_IDLE);
  assign O_DONE              = (state_q == ST_DONE);
  assign O_ERROR             = error_q;
  assign O_CHUNKS_DONE       = chunks_q;
  assign O_DMA_REG_ADDRESS   = reg_addr_q;
  assign O_DMA_REG_DATA      = reg_data_q;
  assign O_DMA_INIT_AXI_TXN  = init_pulse;
  assign O_DMA_TRANSFER_MODE = mode_q;

endmodule

// File: tb/tb_dma_chunk_sequencer.sv
// Bench for dma_chunk_sequencer: table of jobs scored against a command queue,
// plus hand sequences for timeout, abort and reset corners.
module tb_dma_chunk_sequencer;
  import dma_seq_pkg::*;

  localparam int AW = 32;
  localparam int LW = 32;
  localparam int NS = 4;
  localparam int TW = 16;
  localparam logic [LW-1:0] CBL = 32'd4096;
  localparam logic [AW-1:0] CBA = 32'd4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0, abort = 1'b0, txn_done = 1'b0;
  logic [1:0]        slot = '0;
  logic [NS*AW-1:0]  slot_addr = '0;
  logic [NS*2-1:0]   slot_mode = '0;
  logic [LW-1:0]     bytes = '0;
  logic [TW-1:0]     tmo = '0;
  logic              busy, done, err, init;
  logic [LW-1:0]     chunks, dma_data;
  logic [AW-1:0]     dma_addr;
  logic [1:0]        mode;

  dma_chunk_sequencer dut (
    .I_ACLK              (clk),
    .I_ARESET            (rst),
    .I_START             (start),
    .I_ABORT             (abort),
    .I_SLOT              (slot),
    .I_SLOT_ADDR         (slot_addr),
    .I_SLOT_MODE         (slot_mode),
    .I_BYTE_TO_TRANSFER  (bytes),
    .I_TIMEOUT_CYCLES    (tmo),
    .O_BUSY              (busy),
    .O_DONE              (done),
    .O_ERROR             (err),
    .O_CHUNKS_DONE       (chunks),
    .O_DMA_REG_ADDRESS   (dma_addr),
    .O_DMA_REG_DATA      (dma_data),
    .O_DMA_INIT_AXI_TXN  (init),
    .I_DMA_AXI_TXN_DONE  (txn_done),
    .O_DMA_TRANSFER_MODE (mode)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [1:0]    md;
  } cmd_t;

  typedef struct {
    logic [1:0]    slot;
    logic [AW-1:0] base;
    logic [1:0]    md;
    logic [LW-1:0] nbytes;
    int            exp_chunks;
    bit            poke;
  } vec_t;

  cmd_t exp_q[$];
  vec_t vt[5];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int init_cnt = 0, done_cnt = 0;
  int first_init_cyc = -1, last_init_cyc = -1;
  int resp_due = -1;
  bit auto_resp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard: every INIT pulse must match the next queued command.
  always @(negedge clk) begin
    if (!rst && init) begin
      init_cnt++;
      if (first_init_cyc < 0) first_init_cyc = cyc;
      last_init_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_init: got addr %0h len %0d, required no command", dma_addr, dma_data);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        chk("cmd_addr", dma_addr, e.addr);
        chk("cmd_len", dma_data, e.len);
        chk("cmd_mode", mode, e.md);
      end
    end
    if (!rst && done) done_cnt++;
  end

  // One cycle step; drives the automatic DMA responder (TXN_DONE 3 cycles after INIT).
  task automatic tick();
    @(posedge clk);
    #1;
    txn_done = (resp_due == cyc);
    if (txn_done) resp_due = -1;
    if (auto_resp && init && !rst) resp_due = cyc + 3;
  endtask

  task automatic push_job(input logic [AW-1:0] base, input logic [1:0] md, input logic [LW-1:0] nb);
    logic [AW-1:0] a;
    logic [LW-1:0] r;
    cmd_t c;
    a = base;
    r = nb;
    while (r != '0) begin
      c.addr = a;
      c.len  = (r > CBL) ? CBL : r;
      c.md   = md;
      exp_q.push_back(c);
      a = a + CBA;
      r = r - c.len;
    end
  endtask

  task automatic do_start(input logic [1:0] s, input logic [LW-1:0] b, input logic [TW-1:0] t, output int t_cyc);
    first_init_cyc = -1;
    slot  = s;
    bytes = b;
    tmo   = t;
    start = 1'b1;
    t_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d_cyc);
    d_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        d_cyc = cyc;
        break;
      end
      tick();
    end
    if (d_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no O_DONE within %0d cycles", budget);
    end
  endtask

  task automatic wait_init(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = init;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL init_timeout: no INIT within %0d cycles", budget);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t, d, n0, d0;
    auto_resp = 1'b1;
    n0 = init_cnt;
    d0 = done_cnt;
    push_job(v.base, v.md, v.nbytes);
    do_start(v.slot, v.nbytes, '0, t);
    if (v.poke) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(300, d);
    chk("job_chunks", chunks, v.exp_chunks);
    chk("job_error", err, 0);
    chk("job_mode_at_done", mode, v.md);
    chk("first_init_latency", first_init_cyc - t, 3);
    chk("init_spacing", last_init_cyc - first_init_cyc, 7 * (v.exp_chunks - 1));
    chk("done_latency", d - last_init_cyc, 5);
    tick();
    chk("init_count", init_cnt - n0, v.exp_chunks);
    chk("done_pulses", done_cnt - d0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_addr", dma_addr, 0);
    chk("idle_data", dma_data, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t, d, n0, d0, k;

    slot_addr[0*AW +: AW] = 32'h0000_0100;  slot_mode[0*2 +: 2] = TF_MODE_WRITE_RAM;
    slot_addr[1*AW +: AW] = 32'h1000_0000;  slot_mode[1*2 +: 2] = TF_MODE_READ_RAM;
    slot_addr[2*AW +: AW] = 32'h2000_0000;  slot_mode[2*2 +: 2] = TF_MODE_WRITE_RAM;
    slot_addr[3*AW +: AW] = 32'hFFFF_F000;  slot_mode[3*2 +: 2] = TF_MODE_READ_RAM;

    vt[0] = '{2'd1, 32'h1000_0000, TF_MODE_READ_RAM,  32'd10000, 3, 1'b0};
    vt[1] = '{2'd2, 32'h2000_0000, TF_MODE_WRITE_RAM, 32'd4096,  1, 1'b0};
    vt[2] = '{2'd3, 32'hFFFF_F000, TF_MODE_READ_RAM,  32'd8192,  2, 1'b1};
    vt[3] = '{2'd0, 32'h0000_0100, TF_MODE_WRITE_RAM, 32'd1,     1, 1'b0};
    vt[4] = '{2'd1, 32'h1000_0000, TF_MODE_READ_RAM,  32'd4097,  2, 1'b0};

    // Reset state
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", err, 0);
    chk("rst_chunks", chunks, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_data", dma_data, 0);
    chk("rst_init", init, 0);
    chk("rst_mode", mode, 0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    // Table-driven jobs, including address wrap and a start edge while busy
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Zero-length job
    n0 = init_cnt;
    do_start(2'd1, '0, '0, t);
    wait_done(20, d);
    chk("zero_done_latency", d - t, 2);
    chk("zero_chunks", chunks, 0);
    chk("zero_error", err, 0);
    chk("zero_init_count", init_cnt - n0, 0);
    tick();

    // Watchdog timeout at 100 WAIT cycles
    auto_resp = 1'b0;
    n0 = init_cnt;
    exp_q.push_back('{32'h1000_0000, CBL, TF_MODE_READ_RAM});
    do_start(2'd1, 32'd10000, 16'd100, t);
    wait_done(400, d);
    chk("tmo_done_latency", d - first_init_cyc, 101);
    chk("tmo_error", err, 1);
    chk("tmo_chunks", chunks, 0);
    tick();
    chk("tmo_init_count", init_cnt - n0, 1);

    // Watchdog disabled: job parks in WAIT until the DMA answers
    d0 = done_cnt;
    exp_q.push_back('{32'h2000_0000, 32'd100, TF_MODE_WRITE_RAM});
    do_start(2'd2, 32'd100, '0, t);
    repeat (300) tick();
    chk("tmo0_busy", busy, 1);
    chk("tmo0_no_done", done_cnt - d0, 0);
    txn_done = 1'b1;
    wait_done(20, d);
    chk("tmo0_chunks", chunks, 1);
    chk("tmo0_error_cleared", err, 0);
    tick();

    // Abort during the first WAIT of a 3-chunk job
    n0 = init_cnt;
    exp_q.push_back('{32'h1000_0000, CBL, TF_MODE_READ_RAM});
    do_start(2'd1, 32'd10000, '0, t);
    wait_init(20);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();
    txn_done = 1'b1;
    k = cyc;
    wait_done(20, d);
    chk("abort_wait_done_latency", d - k, 2);
    chk("abort_wait_error", err, 1);
    chk("abort_wait_chunks", chunks, 1);
    repeat (10) tick();
    chk("abort_wait_init_count", init_cnt - n0, 1);

    // Abort and TXN_DONE in the same WAIT cycle
    exp_q.push_back('{32'h1000_0000, CBL, TF_MODE_READ_RAM});
    do_start(2'd1, 32'd10000, '0, t);
    wait_init(20);
    tick(); tick();
    abort = 1'b1;
    txn_done = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(20, d);
    chk("abort_same_error", err, 1);
    chk("abort_same_chunks", chunks, 1);
    tick();

    // Abort in ISSUE: no command leaves the block
    n0 = init_cnt;
    do_start(2'd2, 32'd5000, '0, t);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(20, d);
    chk("abort_issue_done_latency", d - t, 3);
    chk("abort_issue_error", err, 1);
    chk("abort_issue_chunks", chunks, 0);
    repeat (5) tick();
    chk("abort_issue_init_count", init_cnt - n0, 0);

    // Reset in the second WAIT, stray TXN_DONE, then a clean restart
    auto_resp = 1'b1;
    d0 = done_cnt;
    push_job(32'h1000_0000, TF_MODE_READ_RAM, 32'd10000);
    do_start(2'd1, 32'd10000, '0, t);
    wait_init(20);
    wait_init(20);
    tick();
    rst = 1'b1;
    auto_resp = 1'b0;
    resp_due = -1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_chunks", chunks, 0);
    chk("midrst_addr", dma_addr, 0);
    chk("midrst_data", dma_data, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_init", init, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    txn_done = 1'b1;
    repeat (4) tick();
    chk("stray_busy", busy, 0);
    chk("stray_chunks", chunks, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_vec(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
